// File: rtl/bus_phase_gen.sv
// Bus-cycle timing generator: one phase counter feeds every divided level,
// strobe, select window and the bus-cycle count, with a wait-state freeze at HOLD_PH.
module bus_phase_gen #(
  parameter int PHASES   = 8,
  parameter int ADDR_ON  = 2,
  parameter int ADDR_OFF = 6,
  parameter int CYC_ON   = 3,
  parameter int CYC_OFF  = 7,
  parameter int LATCH_PH = 6,
  parameter int CPU_PH   = 3,
  parameter int HOLD_PH  = 5,
  parameter int RST_PH   = 0,
  parameter int CNT_W    = 16,
  localparam int PW      = $clog2(PHASES)
) (
  input  logic             clk32,
  input  logic             reset,
  input  logic             hold,
  input  logic             turbo,
  output logic [PW-1:0]    phase,
  output logic [PW-1:0]    div,
  output logic [PW-1:0]    div_en,
  output logic             addrsel,
  output logic             cycsel,
  output logic             latch,
  output logic             cpu_en,
  output logic             turbo_q,
  output logic             cyc_start,
  output logic             hold_ack,
  output logic [CNT_W-1:0] bus_cyc
);

  localparam int TURBO_PH = (CPU_PH + PHASES / 2) % PHASES;

  if (PHASES < 4 || (PHASES & (PHASES - 1)) != 0 ||
      !(ADDR_ON < ADDR_OFF && ADDR_OFF <= PHASES) ||
      !(CYC_ON < CYC_OFF && CYC_OFF <= PHASES)) begin : g_bad_params
    $error("bus_phase_gen: illegal PHASES or select window parameters");
  end

  logic [PW-1:0]    phase_q, phase_d;
  logic [PW-1:0]    div_en_q, div_en_d;
  logic             addrsel_q, addrsel_d, cycsel_q, cycsel_d;
  logic             latch_q, latch_d, cpu_en_q, cpu_en_d;
  logic             turbo_q_q, turbo_d;
  logic             cyc_start_q, cyc_start_d, hold_ack_q, hold_ack_d;
  logic [CNT_W-1:0] bus_cyc_q, bus_cyc_d;
  logic             adv, wrap;

  // Registers are loaded with the decode of the phase they will hold, so every
  // output lines up with phase; strobes carry adv so a frozen phase never repeats one.
  always_comb begin
    adv         = ~(hold & (phase_q == PW'(HOLD_PH)));
    wrap        = adv & (phase_q == PW'(PHASES - 1));
    phase_d     = adv ? phase_q + 1'b1 : phase_q;
    turbo_d     = wrap ? turbo : turbo_q_q;
    bus_cyc_d   = wrap ? bus_cyc_q + 1'b1 : bus_cyc_q;
    div_en_d    = '0;
    for (int i = 0; i < PW; i++) begin
      div_en_d[i] = adv & ~phase_d[i] &
                    ((phase_d & PW'((1 << i) - 1)) == PW'((1 << i) - 1));
    end
    addrsel_d   = (int'(phase_d) >= ADDR_ON) && (int'(phase_d) < ADDR_OFF);
    cycsel_d    = (int'(phase_d) >= CYC_ON) && (int'(phase_d) < CYC_OFF);
    latch_d     = adv & (phase_d == PW'(LATCH_PH));
    cpu_en_d    = adv & ((phase_d == PW'(CPU_PH)) |
                         (turbo_d & (phase_d == PW'(TURBO_PH))));
    cyc_start_d = wrap;
    hold_ack_d  = ~adv;
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      phase_q     <= PW'(RST_PH);
      div_en_q    <= '0;
      addrsel_q   <= 1'b0;
      cycsel_q    <= 1'b0;
      latch_q     <= 1'b0;
      cpu_en_q    <= 1'b0;
      turbo_q_q   <= 1'b0;
      cyc_start_q <= 1'b0;
      hold_ack_q  <= 1'b0;
      bus_cyc_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      div_en_q    <= div_en_d;
      addrsel_q   <= addrsel_d;
      cycsel_q    <= cycsel_d;
      latch_q     <= latch_d;
      cpu_en_q    <= cpu_en_d;
      turbo_q_q   <= turbo_d;
      cyc_start_q <= cyc_start_d;
      hold_ack_q  <= hold_ack_d;
      bus_cyc_q   <= bus_cyc_d;
    end
  end

  assign phase     = phase_q;
  assign div       = phase_q;
  assign div_en    = div_en_q;
  assign addrsel   = addrsel_q;
  assign cycsel    = cycsel_q;
  assign latch     = latch_q;
  assign cpu_en    = cpu_en_q;
  assign turbo_q   = turbo_q_q;
  assign cyc_start = cyc_start_q;
  assign hold_ack  = hold_ack_q;
  assign bus_cyc   = bus_cyc_q;

endmodule

// File: tb/tb_bus_phase_gen.sv
// Bench for bus_phase_gen: default 8-phase instance plus a 16-phase, 4-bit counter
// instance, both compared each cycle against a phase-level reference model.
module tb_bus_phase_gen;

  logic clk32 = 1'b0;
  logic reset, hold, turbo;
  always #5 clk32 = ~clk32;

  logic [2:0]  ph0, dv0, de0;
  logic        as0, cs0, la0, ce0, tq0, st0, ha0;
  logic [15:0] bc0;
  logic [3:0]  ph1, dv1, de1;
  logic        as1, cs1, la1, ce1, tq1, st1, ha1;
  logic [3:0]  bc1;

  bus_phase_gen u_d8 (
    .clk32(clk32), .reset(reset), .hold(hold), .turbo(turbo),
    .phase(ph0), .div(dv0), .div_en(de0), .addrsel(as0), .cycsel(cs0),
    .latch(la0), .cpu_en(ce0), .turbo_q(tq0), .cyc_start(st0),
    .hold_ack(ha0), .bus_cyc(bc0));

  bus_phase_gen #(.PHASES(16), .CPU_PH(5), .CNT_W(4)) u_d16 (
    .clk32(clk32), .reset(reset), .hold(hold), .turbo(turbo),
    .phase(ph1), .div(dv1), .div_en(de1), .addrsel(as1), .cycsel(cs1),
    .latch(la1), .cpu_en(ce1), .turbo_q(tq1), .cyc_start(st1),
    .hold_ack(ha1), .bus_cyc(bc1));

  int checks = 0;
  int failures = 0;

  // Model: current phase, whether it was reached by a step (vs. frozen or reset),
  // whether this is a reset cycle, the latched turbo mode and the bus-cycle count.
  int P[2]  = '{8, 16};
  int LG[2] = '{3, 4};
  int CP[2] = '{3, 5};
  int CW[2] = '{16, 4};
  int m_ph[2], m_ent[2], m_rc[2], m_tq[2], m_bc[2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int den = 0;
      int tph = (CP[k] + P[k] / 2) % P[k];
      for (int i = 0; i < LG[k]; i++)
        if (m_ent[k] != 0 && ((m_ph[k] + 1) % (1 << (i + 1))) == (1 << i)) den |= (1 << i);
      chk("phase",     k, k ? 32'(ph1) : 32'(ph0), m_ph[k]);
      chk("div",       k, k ? 32'(dv1) : 32'(dv0), m_ph[k]);
      chk("div_en",    k, k ? 32'(de1) : 32'(de0), den);
      chk("addrsel",   k, k ? 32'(as1) : 32'(as0), 32'(m_ph[k] >= 2 && m_ph[k] < 6));
      chk("cycsel",    k, k ? 32'(cs1) : 32'(cs0), 32'(m_ph[k] >= 3 && m_ph[k] < 7));
      chk("latch",     k, k ? 32'(la1) : 32'(la0), 32'(m_ent[k] != 0 && m_ph[k] == 6));
      chk("cpu_en",    k, k ? 32'(ce1) : 32'(ce0),
          32'(m_ent[k] != 0 && (m_ph[k] == CP[k] || (m_tq[k] != 0 && m_ph[k] == tph))));
      chk("turbo_q",   k, k ? 32'(tq1) : 32'(tq0), m_tq[k]);
      chk("cyc_start", k, k ? 32'(st1) : 32'(st0), 32'(m_ent[k] != 0 && m_ph[k] == 0));
      chk("hold_ack",  k, k ? 32'(ha1) : 32'(ha0), 32'(m_ent[k] == 0 && m_rc[k] == 0));
      chk("bus_cyc",   k, k ? 32'(bc1) : 32'(bc0), m_bc[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ph[k] = 0; m_ent[k] = 0; m_rc[k] = 1; m_tq[k] = 0; m_bc[k] = 0;
      end else begin
        int adv = !(hold && m_ph[k] == 5);
        m_rc[k] = 0;
        m_ent[k] = adv;
        if (adv != 0) begin
          if (m_ph[k] == P[k] - 1) begin
            m_tq[k] = turbo;
            m_bc[k] = (m_bc[k] + 1) % (1 << CW[k]);
          end
          m_ph[k] = (m_ph[k] + 1) % P[k];
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk32);
    check_all();
    model_step();
    @(posedge clk32);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic goto_phase(input int p);
    for (int n = 0; n < 40 && int'(ph0) != p; n++) cycle();
    chk("goto_phase", 0, 32'(ph0), p);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; turbo = 1'b0;
    @(posedge clk32); #1;
    model_step();
    run(2);
    reset = 1'b0;
    run(20);                               // free run
    goto_phase(2);
    hold = 1'b1; run(4); hold = 1'b0;      // freeze at phase 5
    run(10);
    goto_phase(4);
    turbo = 1'b1; run(20);                 // turbo takes effect after wrap
    goto_phase(2);
    turbo = 1'b0; run(20);
    turbo = 1'b1; goto_phase(4);
    hold = 1'b1; reset = 1'b1; run(1);     // mid-cycle reset over hold/turbo
    reset = 1'b0; hold = 1'b0; turbo = 1'b0;
    run(300);                              // 4-bit counter wraps to 0 on instance 1
    for (int i = 0; i < 3000; i++) begin
      hold  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) turbo = ~turbo;
      reset = ($urandom_range(0, 250) == 0);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
